// File: rtl/seed_pkg.sv
// Shared definitions for the SEED byte-stream front/back ends: block width,
// serializer FSM states and the byte-select helper.
package seed_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHOW     = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

  // Byte k counted from the LSB end of a block-wide word.
  function automatic logic [7:0] byte_sel(input logic [BLOCK_W-1:0] blk, input int k);
    return blk[8*k +: 8];
  endfunction

endpackage

// File: rtl/cipher_to_byte_if.sv
// Bundle of the SEED-core input side and the Pi GPIO byte handshake.
// valid/ready: valid_in is a one-cycle offer accepted only when idle; the Pi
// reads part_out while ready=1, raises ack1, and the next byte follows its fall.
interface cipher_to_byte_if
  import seed_pkg::*;
#(
  parameter int NBYTES = 16
);
  logic                  out_en;
  logic                  valid_in;
  logic [8*NBYTES-1:0]   ciphertext;
  logic                  ack1;
  logic                  abort1;
  logic [7:0]            part_out;
  logic                  ready;
  logic                  busy;
  logic                  done;
  logic                  overrun;
  state_e                dbg_state;

  modport slave (
    input  out_en, valid_in, ciphertext, ack1, abort1,
    output part_out, ready, busy, done, overrun, dbg_state
  );

  modport master (
    output out_en, valid_in, ciphertext, ack1, abort1,
    input  part_out, ready, busy, done, overrun, dbg_state
  );
endinterface

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for an asynchronous Pi-driven level, with a
// registered-history rising-edge detect on the synchronized value.
module pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/cipher_to_byte.sv
// Serializes one SEED result block into bytes, MSB first, using a four-phase
// ready/ack handshake with the Raspberry Pi GPIO strobes.
module cipher_to_byte
  import seed_pkg::*;
#(
  parameter int NBYTES      = 16,
  parameter int SYNC_STAGES = 2
) (
  input logic              clk,
  input logic              reset,
  cipher_to_byte_if.slave  bus
);

  localparam int               IDX_W    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  logic ack_s, ack_rise_unused;
  logic abort_s, abort_rise;

  pin_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.ack1),
    .q_o    (ack_s),
    .rise_o (ack_rise_unused)
  );

  pin_sync #(.STAGES(SYNC_STAGES)) u_abort_sync (
    .clk    (clk),
    .reset  (reset),
    .d_i    (bus.abort1),
    .q_o    (abort_s),
    .rise_o (abort_rise)
  );

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BLOCK_W-1:0]   blk_q, blk_d;
  logic [7:0]           part_q, part_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      blk_q     <= '0;
      part_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      blk_q     <= blk_d;
      part_q    <= part_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // Outputs are computed as next-state values so every port comes from a flop.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_d     = blk_q;
    part_d    = part_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;

    if (abort_rise) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      blk_d   = '0;
      part_d  = '0;
      ready_d = 1'b0;
      busy_d  = 1'b0;
    end else if (bus.out_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.valid_in) begin
            blk_d   = BLOCK_W'(bus.ciphertext);
            idx_d   = '0;
            part_d  = byte_sel(BLOCK_W'(bus.ciphertext), NBYTES - 1);
            ready_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (bus.valid_in) overrun_d = 1'b1;
          if (ack_s) begin
            ready_d = 1'b0;
            state_d = ST_WAIT_LOW;
          end
        end
        ST_WAIT_LOW: begin
          if (bus.valid_in) overrun_d = 1'b1;
          if (!ack_s) begin
            if (idx_q == LAST_IDX) begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = ST_IDLE;
            end else begin
              idx_d   = idx_q + IDX_W'(1);
              part_d  = byte_sel(blk_q, NBYTES - 2 - int'(idx_q));
              ready_d = 1'b1;
              state_d = ST_SHOW;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign bus.part_out  = part_q;
  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_cipher_to_byte.sv
// Bench for cipher_to_byte: table of blocks serialized through a Pi-style
// four-phase handshake, plus abort, overrun, out_en hold and async reset cases.
module tb_cipher_to_byte;
  import seed_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cipher_to_byte_if #(.NBYTES(16)) bus ();

  cipher_to_byte #(.NBYTES(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [127:0] ct;
    logic [7:0]   b0;
    logic [7:0]   b15;
    int           stretch_idx;
    int           stretch;
    logic [7:0]   stretch_byte;
  } vec_t;

  vec_t        vecs [3];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic        ready_prev = 1'b0;
  logic [7:0]  last_byte = 8'h00;
  logic [7:0]  exp_q [$];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock of the bench: advance to the falling edge and run the monitor.
  task automatic tick();
    @(negedge clk);
    if (bus.ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_byte: got %0h expected no byte", bus.part_out);
      end else begin
        check("byte_order", 128'(bus.part_out), 128'(exp_q.pop_front()));
      end
      last_byte = bus.part_out;
    end
    if (bus.done) begin
      done_cnt++;
      check("done_with_busy_low", 128'(bus.busy), 128'(1'b0));
    end
    ready_prev = bus.ready;
  endtask

  task automatic wait_ready(input logic lvl, input string nm);
    int c = 0;
    while (bus.ready !== lvl && c < 200) begin
      tick();
      c++;
    end
    check(nm, 128'(bus.ready), 128'(lvl));
  endtask

  task automatic send_block(input logic [127:0] ct, input logic [7:0] b0);
    for (int i = 0; i < 16; i++) exp_q.push_back(ct[127-8*i -: 8]);
    bus.ciphertext = ct;
    bus.valid_in   = 1'b1;
    tick();
    bus.valid_in   = 1'b0;
    check("capture_ready", 128'(bus.ready), 128'(1'b1));
    check("capture_byte0", 128'(bus.part_out), 128'(b0));
    check("capture_busy", 128'(bus.busy), 128'(1'b1));
  endtask

  task automatic read_bytes(input int first, input int last, input int sidx,
                            input int stretch, input logic [7:0] sbyte);
    for (int i = first; i <= last; i++) begin
      wait_ready(1'b1, "ready_high");
      bus.ack1 = 1'b1;
      wait_ready(1'b0, "ready_fall");
      if (i == sidx) begin
        repeat (stretch) tick();
        check("stretch_ready_low", 128'(bus.ready), 128'(1'b0));
        check("stretch_byte_held", 128'(bus.part_out), 128'(sbyte));
      end
      bus.ack1 = 1'b0;
    end
  endtask

  task automatic wait_done(input int prev);
    int c = 0;
    while (done_cnt == prev && c < 20) begin
      tick();
      c++;
    end
    check("done_pulse", 128'(done_cnt), 128'(prev + 1));
    check("busy_after_done", 128'(bus.busy), 128'(1'b0));
    check("scoreboard_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int d0;
    vecs[0] = '{ct: 128'h000102030405060708090A0B0C0D0E0F, b0: 8'h00, b15: 8'h0F,
                stretch_idx: -1, stretch: 0, stretch_byte: 8'h00};
    vecs[1] = '{ct: 128'hDEADBEEF0123456789ABCDEFF0E1D2C3, b0: 8'hDE, b15: 8'hC3,
                stretch_idx: 3, stretch: 40, stretch_byte: 8'hEF};
    vecs[2] = '{ct: 128'hFF00AA55123456789ABCDEF080017E81, b0: 8'hFF, b15: 8'h81,
                stretch_idx: -1, stretch: 0, stretch_byte: 8'h00};

    reset          = 1'b0;
    bus.out_en     = 1'b1;
    bus.valid_in   = 1'b0;
    bus.ciphertext = '0;
    bus.ack1       = 1'b0;
    bus.abort1     = 1'b0;
    repeat (3) tick();
    check("reset_part_out", 128'(bus.part_out), 128'(8'h00));
    check("reset_ready", 128'(bus.ready), 128'(1'b0));
    check("reset_busy", 128'(bus.busy), 128'(1'b0));
    check("reset_done", 128'(bus.done), 128'(1'b0));
    check("reset_overrun", 128'(bus.overrun), 128'(1'b0));
    check("reset_state", 128'(bus.dbg_state), 128'(ST_IDLE));
    reset = 1'b1;
    tick();

    for (int v = 0; v < 3; v++) begin
      d0 = done_cnt;
      send_block(vecs[v].ct, vecs[v].b0);
      read_bytes(0, 15, vecs[v].stretch_idx, vecs[v].stretch, vecs[v].stretch_byte);
      wait_done(d0);
      check("last_byte", 128'(last_byte), 128'(vecs[v].b15));
      repeat (2) tick();
    end

    // Abort after byte 7: nothing more is shown and no done is produced.
    d0 = done_cnt;
    send_block(vecs[0].ct, 8'h00);
    read_bytes(0, 7, -1, 0, 8'h00);
    bus.abort1 = 1'b1;
    repeat (4) tick();
    check("abort_ready", 128'(bus.ready), 128'(1'b0));
    check("abort_part_out", 128'(bus.part_out), 128'(8'h00));
    check("abort_busy", 128'(bus.busy), 128'(1'b0));
    check("abort_state", 128'(bus.dbg_state), 128'(ST_IDLE));
    check("abort_no_done", 128'(done_cnt), 128'(d0));
    check("abort_last_shown", 128'(last_byte), 128'(8'h07));
    exp_q.delete();
    bus.abort1 = 1'b0;
    tick();
    d0 = done_cnt;
    send_block(vecs[2].ct, 8'hFF);
    read_bytes(0, 15, -1, 0, 8'h00);
    wait_done(d0);

    // out_en low while ack toggles in SHOW: nothing advances.
    repeat (2) tick();
    d0 = done_cnt;
    send_block(vecs[1].ct, 8'hDE);
    bus.out_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.ack1 = ~bus.ack1;
      tick();
    end
    bus.ack1 = 1'b1;
    repeat (3) tick();
    check("hold_ready", 128'(bus.ready), 128'(1'b1));
    check("hold_state", 128'(bus.dbg_state), 128'(ST_SHOW));
    check("hold_byte", 128'(bus.part_out), 128'(8'hDE));
    check("hold_no_done", 128'(done_cnt), 128'(d0));
    bus.out_en = 1'b1;
    wait_ready(1'b0, "resume_ready_fall");
    bus.ack1 = 1'b0;
    read_bytes(1, 15, -1, 0, 8'h00);
    wait_done(d0);
    check("no_overrun_yet", 128'(bus.overrun), 128'(1'b0));

    // Second valid_in while byte 5 is shown.
    repeat (2) tick();
    d0 = done_cnt;
    send_block(vecs[0].ct, 8'h00);
    read_bytes(0, 4, -1, 0, 8'h00);
    wait_ready(1'b1, "byte5_shown");
    bus.ciphertext = vecs[2].ct;
    bus.valid_in   = 1'b1;
    tick();
    bus.valid_in   = 1'b0;
    check("overrun_set", 128'(bus.overrun), 128'(1'b1));
    check("overrun_byte5_kept", 128'(bus.part_out), 128'(8'h05));
    read_bytes(5, 15, -1, 0, 8'h00);
    wait_done(d0);
    check("overrun_sticky", 128'(bus.overrun), 128'(1'b1));
    check("overrun_last_byte", 128'(last_byte), 128'(8'h0F));

    // Asynchronous reset between clock edges, mid-block.
    repeat (2) tick();
    send_block(vecs[2].ct, 8'hFF);
    read_bytes(0, 2, -1, 0, 8'h00);
    wait_ready(1'b1, "byte3_shown");
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("areset_part_out", 128'(bus.part_out), 128'(8'h00));
    check("areset_ready", 128'(bus.ready), 128'(1'b0));
    check("areset_busy", 128'(bus.busy), 128'(1'b0));
    check("areset_done", 128'(bus.done), 128'(1'b0));
    check("areset_overrun", 128'(bus.overrun), 128'(1'b0));
    check("areset_state", 128'(bus.dbg_state), 128'(ST_IDLE));
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
